dsp_z_collector: RTL and testbench
==================================

DSP_Z_COLLECTOR -- requirements
Module: dsp_z_collector

Interface
REQ-001 Parameter NBITS_Z, default 38, SHALL set the width of the DSP result word consumed and buffered.
REQ-002 Parameter DEPTH, default 8, SHALL set the FIFO entry count; it must be a power of two and at least 2.
REQ-003 clock_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_i  in  1  SHALL be a synchronous, active-high reset.
REQ-005 issue_i  in  1  SHALL pulse in the same cycle operands are presented to the DSP stage a_i/b_i.
REQ-006 register_inputs_i  in  1  SHALL be a static copy of the DSP register_inputs_i setting.
REQ-007 z_i  in  NBITS_Z  SHALL carry the DSP z_o result.
REQ-008 flush_i  in  1  SHALL be a synchronous clear of buffered and in-flight results.
REQ-009 clear_ovf_i  in  1  SHALL clear the sticky overflow flag.
REQ-010 out_ready_i  in  1  SHALL be the downstream ready signal.
REQ-011 out_valid_o  out  1  SHALL indicate that the FIFO head is valid.
REQ-012 out_data_o  out  NBITS_Z  SHALL present the FIFO head word, show-ahead.
REQ-013 level_o  out  clog2(DEPTH)+1  SHALL report the current entry count.
REQ-014 full_o and empty_o  out  1 each  SHALL report level_o==DEPTH and level_o==0 respectively.
REQ-015 overflow_o  out  1  SHALL be a sticky flag that a result was dropped.

Function
REQ-016 A 2-stage tag shift register SHALL carry issue_i; the capture tap SHALL be stage 1 when register_inputs_i=0 and stage 2 when register_inputs_i=1.
REQ-017 When the tap is set in cycle t, z_i SHALL be written to the FIFO tail at the end of cycle t; out_valid_o SHALL rise in cycle t+1 if the FIFO was empty.
REQ-018 Issue-to-out_valid_o latency SHALL be 2 cycles for register_inputs_i=0 and 3 cycles for register_inputs_i=1.
REQ-019 Back-to-back issue_i pulses SHALL each produce one entry; there is no throughput limit.
REQ-020 A pop SHALL occur when out_valid_o and out_ready_i are both 1; the head SHALL advance on the next edge.
REQ-021 A push SHALL be accepted when not full, or when full with a pop in the same cycle; level is unchanged in the full-with-pop case.
REQ-022 A push to a full FIFO without a pop SHALL be dropped; overflow_o SHALL be set from the next cycle; FIFO contents are unchanged.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL NOT occur, because out_valid_o=0; the push is accepted normally.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level_o SHALL be computed from pointers carrying one extra bit.
REQ-025 flush_i SHALL empty the FIFO and clear the tag pipeline on the next edge; an issue_i in the flush cycle SHALL be discarded; overflow_o SHALL be retained.
REQ-026 When clear_ovf_i and a dropped push coincide, overflow_o SHALL remain 1 (set wins).
REQ-027 register_inputs_i SHALL change only while the tag pipeline is empty; behaviour otherwise is undefined.

Reset
REQ-028 reset_i SHALL override flush_i and all other inputs, including mid-operation.
REQ-029 After reset: out_valid_o=0, out_data_o=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, tag pipeline cleared, pointers=0; in-flight results SHALL be lost.
REQ-030 FIFO storage SHALL need no reset; out_data_o SHALL be forced to 0 while empty.

Configuration
REQ-031 Macro DSP_ZCOL_PEAK_EN SHALL add output peak_o [NBITS_Z] and input peak_clr_i.
REQ-032 With DSP_ZCOL_PEAK_EN, peak_o SHALL hold the largest signed two's-complement value accepted into the FIFO since reset, flush_i or peak_clr_i; its reset value is the most-negative value.
REQ-033 Without DSP_ZCOL_PEAK_EN, the ports and logic SHALL be absent and all other behaviour identical.

Structure
REQ-034 Package dsp_zcol_pkg SHALL hold the NBITS_Z and DEPTH defaults, the pointer width constant, and the typedef z_word_t.
REQ-035 Sub-module dsp_zcol_fifo (storage, pointers, level, full and empty) SHALL be instantiated once; tag pipeline, overflow and peak logic stay in the top level.

Verification
REQ-036 register_inputs_i=0, issue_i at t=5, z_i=38'h1234 at t=6 -> out_valid_o=1 at t=7 with out_data_o=38'h1234.
REQ-037 register_inputs_i=1, issue_i for 4 consecutive cycles, z_i=1,2,3,4, out_ready_i=1 -> outputs 1,2,3,4 on consecutive cycles, level_o<=1.
REQ-038 DEPTH=8, out_ready_i=0, 9 results -> full_o=1, level_o=8, overflow_o=1, then a drain yields the first 8 values in order.
REQ-039 Full FIFO with out_ready_i=1 and a push in the same cycle -> level_o stays 8, overflow_o stays 0, order is preserved across pointer wrap.
REQ-040 3 entries buffered and one tag in flight, then flush_i -> level_o=0 next cycle and no late entry; repeat with reset_i -> all outputs at reset values.
REQ-041 DSP_ZCOL_PEAK_EN, results -5, 7, -100, 3 -> peak_o=7; after peak_clr_i, result -9 -> peak_o=-9.

Source files
------------

// File: rtl/dsp_zcol_pkg.sv
// rtl/dsp_zcol_pkg.sv - shared defaults and types for the DSP result collector
package dsp_zcol_pkg;

  // Default width of one DSP result word
  localparam int NBITS_Z_DEF = 38;

  // Default FIFO depth (power of two, at least 2)
  localparam int DEPTH_DEF = 8;

  // FIFO pointers carry one extra bit so that full and empty can be told apart
  localparam int PTR_W = $clog2(DEPTH_DEF) + 1;

  typedef logic [NBITS_Z_DEF-1:0] z_word_t;

endpackage

// File: rtl/dsp_zcol_fifo.sv
// rtl/dsp_zcol_fifo.sv - show-ahead result FIFO with wrap-bit pointers, level, full and empty
module dsp_zcol_fifo
  import dsp_zcol_pkg::*;
#(
  parameter int NBITS_Z = NBITS_Z_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [NBITS_Z-1:0]     data_i,
  input  logic                   pop_i,
  output logic [NBITS_Z-1:0]     data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [NBITS_Z-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_q, wr_d;
  logic [AW:0]        rd_q, rd_d;
  logic               do_push;
  logic               do_pop;

  // Full when the indices match but the wrap bits differ
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

  // A push into a full FIFO still fits when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage is never reset, so the head is masked to zero while empty
  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer next-state: flush rewinds both pointers, otherwise advance on push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  // Pointer registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write at the tail; no reset needed on the data array
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dsp_z_collector.sv
// rtl/dsp_z_collector.sv - DSP z_o collector: issue tag pipeline, result FIFO, sticky overflow; DSP_ZCOL_PEAK_EN adds a signed peak tracker
module dsp_z_collector
  import dsp_zcol_pkg::*;
#(
  parameter int NBITS_Z = NBITS_Z_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   issue_i,
  input  logic                   register_inputs_i,
  input  logic [NBITS_Z-1:0]     z_i,
  input  logic                   flush_i,
  input  logic                   clear_ovf_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [NBITS_Z-1:0]     out_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
`ifdef DSP_ZCOL_PEAK_EN
  ,
  input  logic                   peak_clr_i,
  output logic [NBITS_Z-1:0]     peak_o
`endif
);

  logic [1:0] tag_q, tag_d;
  logic       overflow_q, overflow_d;
  logic       tap;
  logic       push;
  logic       pop;
  logic       drop;

  // The DSP result lands one cycle after issue, or two with its input registers enabled
  assign tap  = register_inputs_i ? tag_q[1] : tag_q[0];
  assign push = tap & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;
  assign drop = push & full_o & ~pop;

  assign out_valid_o = ~empty_o;
  assign overflow_o  = overflow_q;

  // Tag shift: flush discards both in-flight tags and any issue in the same cycle
  always_comb begin
    tag_d = flush_i ? 2'b00 : {tag_q[0], issue_i};
  end

  // Tag pipeline register
  always_ff @(posedge clock_i) begin
    if (reset_i) tag_q <= 2'b00;
    else         tag_q <= tag_d;
  end

  // Sticky overflow: a dropped push outranks a same-cycle clear; flush keeps it
  always_comb begin
    overflow_d = overflow_q;
    if (clear_ovf_i) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;
  end

  // Overflow flag register
  always_ff @(posedge clock_i) begin
    if (reset_i) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  dsp_zcol_fifo #(
    .NBITS_Z (NBITS_Z),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (z_i),
    .pop_i   (pop),
    .data_o  (out_data_o),
    .level_o (level_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

`ifdef DSP_ZCOL_PEAK_EN
  localparam logic [NBITS_Z-1:0] PEAK_MIN = {1'b1, {(NBITS_Z-1){1'b0}}};

  logic [NBITS_Z-1:0] peak_q, peak_d;
  logic               accepted;

  // Only words that actually enter the FIFO count towards the peak
  assign accepted = push & (~full_o | pop);
  assign peak_o   = peak_q;

  // Peak next-state: flush or clear restart from the most-negative value
  always_comb begin
    peak_d = peak_q;
    if (flush_i || peak_clr_i) begin
      peak_d = PEAK_MIN;
    end else if (accepted && ($signed(z_i) > $signed(peak_q))) begin
      peak_d = z_i;
    end
  end

  // Peak register
  always_ff @(posedge clock_i) begin
    if (reset_i) peak_q <= PEAK_MIN;
    else         peak_q <= peak_d;
  end
`endif

endmodule

// File: tb/tb_dsp_z_collector.sv
// tb/tb_dsp_z_collector.sv - self-checking bench for dsp_z_collector (vector table plus scoreboard)
module tb_dsp_z_collector;
  import dsp_zcol_pkg::*;

  localparam int LW = $clog2(DEPTH_DEF) + 1;
  localparam z_word_t ZMIN = {1'b1, {(NBITS_Z_DEF-1){1'b0}}};

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          issue_i;
  logic          register_inputs_i;
  z_word_t       z_i;
  logic          flush_i;
  logic          clear_ovf_i;
  logic          out_ready_i;
  logic          out_valid_o;
  z_word_t       out_data_o;
  logic [LW-1:0] level_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
`ifdef DSP_ZCOL_PEAK_EN
  logic          peak_clr_i;
  z_word_t       peak_o;
`endif

  dsp_z_collector dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .issue_i           (issue_i),
    .register_inputs_i (register_inputs_i),
    .z_i               (z_i),
    .flush_i           (flush_i),
    .clear_ovf_i       (clear_ovf_i),
    .out_ready_i       (out_ready_i),
    .out_valid_o       (out_valid_o),
    .out_data_o        (out_data_o),
    .level_o           (level_o),
    .full_o            (full_o),
    .empty_o           (empty_o),
    .overflow_o        (overflow_o)
`ifdef DSP_ZCOL_PEAK_EN
    ,
    .peak_clr_i        (peak_clr_i),
    .peak_o            (peak_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic    ri;
    z_word_t z;
    int      lat;
  } vec_t;

  vec_t    vecs [5];
  z_word_t exp_q [$];
  z_word_t zs [4096];
  bit      zs_v [4096];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      nvalid, first_v, last_v, nbad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; single-cycle pulses drop, z_i shows a scheduled result or noise
  task automatic step();
    @(posedge clock_i);
    #1;
    cyc++;
    issue_i     = 1'b0;
    flush_i     = 1'b0;
    clear_ovf_i = 1'b0;
    reset_i     = 1'b0;
`ifdef DSP_ZCOL_PEAK_EN
    peak_clr_i  = 1'b0;
`endif
    if (zs_v[cyc % 4096]) z_i = zs[cyc % 4096];
    else                  z_i = z_word_t'({$urandom(), $urandom()});
  endtask

  // Issue in the current cycle; the DSP answers 1 or 2 cycles later on z_i
  task automatic issue(input z_word_t v, input bit expect_acc);
    int idx;
    idx = (cyc + (register_inputs_i ? 2 : 1)) % 4096;
    issue_i  = 1'b1;
    zs[idx]   = v;
    zs_v[idx] = 1'b1;
    if (expect_acc) exp_q.push_back(v);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready_i = 1'b1;
    while (n < 40) begin
      @(negedge clock_i);
      if (empty_o) break;
      step();
      n++;
    end
    out_ready_i = 1'b0;
    chk({name, "_in_time"}, n < 40, 1'b1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
    step();
  endtask

  // Scoreboard: every handshake must deliver the oldest outstanding expected word
  always @(negedge clock_i) begin
    if (reset_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got data %0h, required no output", out_data_o);
      end else begin
        z_word_t e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          errors++;
          $display("FAIL sb_pop: got %0h, required %0h", out_data_o, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 38'h12_3400_1234 & 38'h0_0000_FFFF, 2};
    vecs[1] = '{1'b0, 38'h3F_FFFF_FFFF, 2};
    vecs[2] = '{1'b1, 38'h20_0000_0001, 3};
    vecs[3] = '{1'b1, 38'h00_0000_0000, 3};
    vecs[4] = '{1'b0, 38'h15_5555_5555, 2};

    for (int i = 0; i < 4096; i++) zs_v[i] = 1'b0;
    reset_i = 1'b1; issue_i = 1'b0; register_inputs_i = 1'b0; z_i = '0;
    flush_i = 1'b0; clear_ovf_i = 1'b0; out_ready_i = 1'b0;
`ifdef DSP_ZCOL_PEAK_EN
    peak_clr_i = 1'b0;
`endif
    step();
    reset_i = 1'b1;
    step();

    @(negedge clock_i);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_data", out_data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
`ifdef DSP_ZCOL_PEAK_EN
    chk("rst_peak", peak_o, ZMIN);
`endif
    step();

    // Single-result latency table (vector 0 is the 38'h1234 case)
    for (int v = 0; v < 5; v++) begin
      register_inputs_i = vecs[v].ri;
      out_ready_i = 1'b0;
      step(); step();
      issue(vecs[v].z, 1'b1);
      step();
      for (int k = 1; k <= vecs[v].lat; k++) begin
        out_ready_i = (k == vecs[v].lat);
        @(negedge clock_i);
        chk($sformatf("vec%0d_valid_c%0d", v, k), out_valid_o, (k == vecs[v].lat));
        if (k == vecs[v].lat) begin
          chk($sformatf("vec%0d_data", v), out_data_o, vecs[v].z);
          chk($sformatf("vec%0d_level", v), level_o, 1);
        end
        step();
      end
      out_ready_i = 1'b0;
      @(negedge clock_i);
      chk($sformatf("vec%0d_empty_after", v), empty_o, 1'b1);
      step();
    end

    // Back-to-back issues with registered inputs and ready held high
    register_inputs_i = 1'b1;
    out_ready_i = 1'b1;
    step(); step();
    nvalid = 0; first_v = -1; last_v = -1; nbad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) issue(z_word_t'(i + 1), 1'b1);
      @(negedge clock_i);
      if (level_o > 1) nbad++;
      if (out_valid_o) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nvalid++;
      end
      step();
    end
    chk("b2b_level_gt1_cycles", nbad, 0);
    chk("b2b_valid_count", nvalid, 4);
    chk("b2b_first_valid", first_v, 3);
    chk("b2b_last_valid", last_v, 6);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // Nine results into an eight-deep FIFO; the drop coincides with clear_ovf_i
    register_inputs_i = 1'b0;
    out_ready_i = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) issue(z_word_t'(100 + i), (i < 8));
      if (i == 9) begin
        clear_ovf_i = 1'b1;
        @(negedge clock_i);
        chk("ovf_before_drop", overflow_o, 1'b0);
        chk("full_before_drop", full_o, 1'b1);
      end
      step();
    end
    @(negedge clock_i);
    chk("ovf_set_wins", overflow_o, 1'b1);
    chk("full_after_drop", full_o, 1'b1);
    chk("level_after_drop", level_o, 8);
    step();
    drain("drain_full");

    // Flush with three buffered and one tag in flight; overflow must survive
    register_inputs_i = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      issue(z_word_t'(200 + i), 1'b1);
      step();
    end
    step(); step();
    @(negedge clock_i);
    chk("flush_pre_level", level_o, 3);
    step();
    issue(z_word_t'(250), 1'b0);
    step();
    issue(z_word_t'(251), 1'b0);
    flush_i = 1'b1;
    step();
    exp_q.delete();
    @(negedge clock_i);
    chk("flush_level", level_o, 0);
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_data", out_data_o, 0);
    chk("flush_ovf_kept", overflow_o, 1'b1);
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock_i);
      if (level_o != 0 || out_valid_o) nbad++;
    end
    chk("flush_no_late_entry", nbad, 0);
    step();
    clear_ovf_i = 1'b1;
    step();
    @(negedge clock_i);
    chk("ovf_cleared", overflow_o, 1'b0);
    step();

    // Same situation, but reset (with flush also high) takes over
    for (int i = 0; i < 3; i++) begin
      issue(z_word_t'(300 + i), 1'b1);
      step();
    end
    step(); step();
    issue(z_word_t'(350), 1'b0);
    step();
    reset_i = 1'b1;
    flush_i = 1'b1;
    issue_i = 1'b1;
    step();
    exp_q.delete();
    @(negedge clock_i);
    chk("rst2_level", level_o, 0);
    chk("rst2_empty", empty_o, 1'b1);
    chk("rst2_full", full_o, 1'b0);
    chk("rst2_valid", out_valid_o, 1'b0);
    chk("rst2_data", out_data_o, 0);
    nbad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clock_i);
      if (level_o != 0) nbad++;
    end
    chk("rst2_no_late_entry", nbad, 0);
    step();

    // Full FIFO with push and pop together across pointer wrap
    register_inputs_i = 1'b0;
    out_ready_i = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      issue(z_word_t'(400 + i), 1'b1);
      step();
    end
    step();
    @(negedge clock_i);
    chk("wrap_prefill_full", full_o, 1'b1);
    step();
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) issue(z_word_t'(500 + i), 1'b1);
      out_ready_i = (i >= 1 && i <= 8);
      @(negedge clock_i);
      if (i >= 1 && (level_o != 8 || overflow_o)) nbad++;
      step();
    end
    out_ready_i = 1'b0;
    chk("wrap_level8_no_ovf", nbad, 0);
    @(negedge clock_i);
    chk("wrap_level_end", level_o, 8);
    step();
    drain("drain_wrap");

`ifdef DSP_ZCOL_PEAK_EN
    // Signed peak over accepted words, then restart with peak_clr_i
    out_ready_i = 1'b1;
    step();
    issue(z_word_t'(-5), 1'b1);   step();
    issue(z_word_t'(7), 1'b1);    step();
    issue(z_word_t'(-100), 1'b1); step();
    issue(z_word_t'(3), 1'b1);    step();
    step(); step(); step();
    @(negedge clock_i);
    chk("peak_max", peak_o, z_word_t'(7));
    step();
    peak_clr_i = 1'b1;
    step();
    @(negedge clock_i);
    chk("peak_cleared", peak_o, ZMIN);
    step();
    issue(z_word_t'(-9), 1'b1);
    step(); step(); step();
    @(negedge clock_i);
    chk("peak_after_clr", peak_o, z_word_t'(-9));
    step();
    out_ready_i = 1'b0;
    chk("peak_sb_empty", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
